// File: rtl/seq_detector_param.sv
// rtl/seq_detector_param.sv - parameterised Mealy serial-pattern detector with runtime-loadable pattern
//
// Optional feature macro: SEQ_DETECTOR_PARAM_COUNT_EN (saturating match counter).
//
// Ports:
//   clk          sole clock, rising edge
//   rst          synchronous active-high reset
//   x_valid      x carries a stream bit this cycle
//   x            serial data bit
//   cfg_load     capture cfg_pattern / cfg_len / cfg_overlap this cycle
//   cfg_pattern  right-aligned pattern, bit [len-1] oldest, bit [0] final
//   cfg_len      pattern length (0 disables, > MAX_LEN clamps)
//   cfg_overlap  1 = overlapping detection, 0 = non-overlapping
//   z            combinational match flag, same cycle as the final bit
//   match_count  saturating match count (0 when the counter is not built)
//   cnt_sat      sticky saturation flag (0 when the counter is not built)

module seq_detector_param #(
    parameter int                 MAX_LEN     = 8,
    parameter int                 CNT_W       = 8,
    parameter logic [MAX_LEN-1:0] DEF_PATTERN = MAX_LEN'(8'b0000_1010),
    parameter int                 DEF_LEN     = 4,
    parameter bit                 DEF_OVERLAP = 1'b1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             x_valid,
    input  logic                             x,
    input  logic                             cfg_load,
    input  logic [MAX_LEN-1:0]               cfg_pattern,
    input  logic [$clog2(MAX_LEN+1)-1:0]     cfg_len,
    input  logic                             cfg_overlap,
    output logic                             z,
    output logic [CNT_W-1:0]                 match_count,
    output logic                             cnt_sat
);

    localparam int LW = $clog2(MAX_LEN+1);

    logic [MAX_LEN-1:0] pat;
    logic [LW-1:0]      len;
    logic               ovl;
    logic [MAX_LEN-2:0] hist;
    logic [LW-1:0]      fill;

    logic [MAX_LEN-1:0] cand;
    logic [MAX_LEN-1:0] mask;
    logic [LW:0]        fill_p1;
    logic               accept;
    logic               enough;

    assign cand    = {hist, x};
    assign accept  = x_valid & ~cfg_load;
    // fill >= len-1 rewritten as fill+1 >= len so len=0 cannot underflow
    assign fill_p1 = {1'b0, fill} + (LW+1)'(1);
    assign enough  = (fill_p1 >= {1'b0, len});

    always_comb begin
        mask = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            mask[i] = (LW'(i) < len);
        end
    end

    assign z = accept & ~rst & (len != '0) & enough & ((cand & mask) == (pat & mask));

    always_ff @(posedge clk) begin
        if (rst) begin
            pat  <= DEF_PATTERN;
            len  <= LW'(DEF_LEN);
            ovl  <= DEF_OVERLAP;
            hist <= '0;
            fill <= '0;
        end else if (cfg_load) begin
            pat  <= cfg_pattern;
            len  <= (cfg_len > LW'(MAX_LEN)) ? LW'(MAX_LEN) : cfg_len;
            ovl  <= cfg_overlap;
            hist <= '0;
            fill <= '0;
        end else if (x_valid) begin
            hist <= cand[MAX_LEN-2:0];
            if (z && !ovl) begin
                // non-overlapping: the next match must be built from fresh bits
                fill <= '0;
            end else if (fill != LW'(MAX_LEN)) begin
                fill <= fill + LW'(1);
            end
        end
    end

`ifdef SEQ_DETECTOR_PARAM_COUNT_EN
    logic [CNT_W-1:0] cnt_q;
    logic             sat_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            sat_q <= 1'b0;
        end else if (z) begin
            // a match arriving while already at all-ones marks saturation
            if (&cnt_q) begin
                sat_q <= 1'b1;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign match_count = cnt_q;
    assign cnt_sat     = sat_q;
`else
    assign match_count = '0;
    assign cnt_sat     = 1'b0;
`endif

endmodule

// File: tb/tb_seq_detector_param.sv
// tb/tb_seq_detector_param.sv - self-checking bench for seq_detector_param
module tb_seq_detector_param;

    localparam int MAX_LEN = 8;
    localparam int LW      = 4;
    localparam int CNT_W   = 2;
    localparam int CNT_MAX = 3;

    logic               clk = 1'b0;
    logic               rst;
    logic               x_valid;
    logic               x;
    logic               cfg_load;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [LW-1:0]      cfg_len;
    logic               cfg_overlap;
    logic               z;
    logic [CNT_W-1:0]   match_count;
    logic               cnt_sat;

    int n_checks = 0;
    int n_pass   = 0;
    bit exp_q[$];
    int exp_cnt  = 0;
    bit exp_sat  = 1'b0;

    always #5 clk = ~clk;

    seq_detector_param #(
        .MAX_LEN (MAX_LEN),
        .CNT_W   (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .x_valid     (x_valid),
        .x           (x),
        .cfg_load    (cfg_load),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cfg_overlap (cfg_overlap),
        .z           (z),
        .match_count (match_count),
        .cnt_sat     (cnt_sat)
    );

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // One clock: drive, queue expected z, sample z mid-cycle, then check counter after the edge
    task automatic cycle(input string tag, input bit r, input bit ld, input bit v, input bit xi, input bit ez);
        bit e;
        rst      = r;
        cfg_load = ld;
        x_valid  = v;
        x        = xi;
        exp_q.push_back(ez);
        @(negedge clk);
        e = exp_q.pop_front();
        check_eq({tag, " z"}, int'(z), int'(e));
        @(posedge clk);
        #1;
        if (r) begin
            exp_cnt = 0;
            exp_sat = 1'b0;
        end else if (e) begin
            if (exp_cnt == CNT_MAX) exp_sat = 1'b1;
            else exp_cnt++;
        end
`ifdef SEQ_DETECTOR_PARAM_COUNT_EN
        check_eq({tag, " count"}, int'(match_count), exp_cnt);
        check_eq({tag, " sat"}, int'(cnt_sat), int'(exp_sat));
`else
        check_eq({tag, " count"}, int'(match_count), 0);
        check_eq({tag, " sat"}, int'(cnt_sat), 0);
`endif
    endtask

    task automatic do_reset(input string tag);
        cycle(tag, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    endtask

    task automatic load(input string tag, input logic [7:0] p, input logic [3:0] l, input bit o,
                        input bit v, input bit xi);
        cfg_pattern = p;
        cfg_len     = l;
        cfg_overlap = o;
        cycle(tag, 1'b0, 1'b1, v, xi, 1'b0);
    endtask

    // bits/zs are written oldest-first, left to right
    task automatic feed(input string tag, input logic [15:0] bits, input logic [15:0] zs, input int n);
        for (int i = 0; i < n; i++) begin
            cycle($sformatf("%s b%0d", tag, i + 1), 1'b0, 1'b0, 1'b1, bits[n-1-i], zs[n-1-i]);
        end
    endtask

    task automatic bubble(input string tag);
        cycle(tag, 1'b0, 1'b0, 1'b0, 1'($urandom_range(1)), 1'b0);
    endtask

    initial begin
        rst = 1'b1; x_valid = 1'b0; x = 1'b0; cfg_load = 1'b0;
        cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0;
        @(posedge clk);
        #1;

        // reset state and default "1010" overlapping
        do_reset("reset");
        feed("dflt", 16'b101010, 16'b000101, 6);

        // non-overlapping vs overlapping
        do_reset("rst2");
        load("ld_novl", 8'b1010, 4'd4, 1'b0, 1'b0, 1'b0);
        feed("novl", 16'b10101010, 16'b00010001, 8);
        do_reset("rst3");
        load("ld_ovl", 8'b1010, 4'd4, 1'b1, 1'b0, 1'b0);
        feed("ovl", 16'b10101010, 16'b00010101, 8);

        // detection spans bubbles
        do_reset("rst4");
        cycle("bub b1", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) bubble("bub gap1");
        cycle("bub b2", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) bubble("bub gap2");
        cycle("bub b3", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) bubble("bub gap3");
        cycle("bub b4", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);

        // load-cycle data bit is discarded
        do_reset("rst5");
        load("ld_111", 8'b111, 4'd3, 1'b1, 1'b1, 1'b1);
        feed("p111", 16'b1111, 16'b0011, 4);

        // length 1 and counter saturation
        do_reset("rst6");
        load("ld_len1", 8'b1, 4'd1, 1'b1, 1'b0, 1'b0);
        feed("len1", 16'b11111, 16'b11111, 5);
        do_reset("rst_sat");

        // reset mid-pattern discards the partial match
        feed("pre", 16'b101, 16'b000, 3);
        do_reset("rst_mid");
        feed("post0", 16'b0, 16'b0, 1);
        feed("post", 16'b1010, 16'b0001, 4);

        // length 0 disables detection
        load("ld_len0", 8'b1010, 4'd0, 1'b1, 1'b0, 1'b0);
        feed("len0", 16'b10101010, 16'b0, 8);

        // over-length clamps to MAX_LEN
        load("ld_clamp", 8'hFF, 4'd15, 1'b1, 1'b0, 1'b0);
        feed("clamp", 16'b111111111, 16'b000000011, 9);

        // reset wins over a concurrent load
        cfg_pattern = 8'b0; cfg_len = 4'd0; cfg_overlap = 1'b0;
        cycle("rst_vs_ld", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        feed("after_rl", 16'b1010, 16'b0001, 4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
